uart_recv_fifo: RTL

- Next-generation UART receiver: runtime baud divider, configurable parity and stop bits, 3-sample majority voting and a receive FIFO with per-byte error flags.
- Delivers received bytes on a valid/ready stream and drives cts from FIFO fill level.
- Sits between the serial pin and the host-side command/bus logic.

---
 rtl/uart_recv_fifo.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_recv_fifo.sv
// UART receiver: 2-FF synchroniser, 3-sample majority voting, parity/stop checks and a FWFT receive FIFO.
// Define UART_RECV_BREAK_DET_EN to add the brk output and keep break frames out of the FIFO.
module uart_recv_fifo #(
  parameter int DATABITS   = 8,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int CTS_MARGIN = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        soft_reset,
  input  logic [DIV_W-1:0]            baud_div,
  input  logic [1:0]                  parity_mode,
  input  logic                        two_stop,
  input  logic                        rx,
  output logic                        cts,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATABITS-1:0]         out_data,
  output logic                        out_perr,
  output logic                        out_ferr,
  output logic                        overrun,
  input  logic                        ovr_clr,
  output logic [$clog2(FIFO_DEPTH):0] fill
`ifdef UART_RECV_BREAK_DET_EN
  ,
  output logic                        brk
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);
  localparam logic [3:0]       LAST_BIT  = 4'(DATABITS - 1);
  localparam logic [AW:0]      CTS_LIMIT = (AW+1)'(FIFO_DEPTH - CTS_MARGIN);
  localparam logic [AW:0]      FULL_CNT  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

  logic                rx_meta, rxs, rxs_prev;
  state_t              state;
  logic [DIV_W-1:0]    cnt, div_lat, mid, cnt_inc;
  logic [1:0]          par_lat;
  logic                two_lat;
  logic                s0, s1, vote;
  logic [DATABITS-1:0] shreg;
  logic [3:0]          bit_idx;
  logic                perr_reg;
  logic                at_m1, at_mid, at_dec, at_wrap, par_en;
  logic                commit, frame_ferr, is_break, push;
`ifdef UART_RECV_BREAK_DET_EN
  logic                pbit_reg, brk_pend;
`endif

  logic [DATABITS+1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr, rd_next;
  logic [AW:0]         count, count_next;
  logic                full, do_pop, do_push, ovr_set;
  logic [DATABITS+1:0] din, head_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      rx_meta  <= rx;
      rxs      <= rx_meta;
      rxs_prev <= rxs;
    end
  end

  always_comb begin
    mid        = div_lat >> 1;
    at_m1      = (cnt == mid - ONE);
    at_mid     = (cnt == mid);
    at_dec     = (cnt == mid + ONE);
    at_wrap    = (cnt == div_lat);
    cnt_inc    = at_wrap ? '0 : cnt + ONE;
    vote       = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
    par_en     = (par_lat == 2'd1) || (par_lat == 2'd2);
    commit     = ((state == STOP1) && at_dec && (!vote || !two_lat)) ||
                 ((state == STOP2) && at_dec);
    frame_ferr = ~vote;
    is_break   = 1'b0;
`ifdef UART_RECV_BREAK_DET_EN
    is_break   = frame_ferr && (shreg == '0) && !pbit_reg;
`endif
    push       = commit && !is_break && !soft_reset;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= WAIT_IDLE;
      cnt      <= '0;
      div_lat  <= '0;
      par_lat  <= 2'd0;
      two_lat  <= 1'b0;
      s0       <= 1'b1;
      s1       <= 1'b1;
      shreg    <= '0;
      bit_idx  <= 4'd0;
      perr_reg <= 1'b0;
`ifdef UART_RECV_BREAK_DET_EN
      pbit_reg <= 1'b0;
      brk_pend <= 1'b0;
      brk      <= 1'b0;
`endif
    end else if (soft_reset) begin
      state <= WAIT_IDLE;
      cnt   <= '0;
`ifdef UART_RECV_BREAK_DET_EN
      brk_pend <= 1'b0;
      brk      <= 1'b0;
`endif
    end else begin
`ifdef UART_RECV_BREAK_DET_EN
      brk <= 1'b0;
      if (commit && is_break) brk_pend <= 1'b1;
`endif
      if (at_m1)  s0 <= rxs;
      if (at_mid) s1 <= rxs;
      case (state)
        WAIT_IDLE: begin
          if (rxs) begin
            state <= IDLE;
`ifdef UART_RECV_BREAK_DET_EN
            brk      <= brk_pend;
            brk_pend <= 1'b0;
`endif
          end
        end
        IDLE: begin
          if (rxs_prev && !rxs) begin
            state    <= START;
            cnt      <= '0;
            div_lat  <= baud_div;
            par_lat  <= parity_mode;
            two_lat  <= two_stop;
            bit_idx  <= 4'd0;
            perr_reg <= 1'b0;
`ifdef UART_RECV_BREAK_DET_EN
            pbit_reg <= 1'b0;
`endif
          end
        end
        START: begin
          cnt <= cnt_inc;
          if (at_dec && vote) state <= IDLE;
          else if (at_wrap)   state <= DATA;
        end
        DATA: begin
          cnt <= cnt_inc;
          if (at_dec) shreg <= {vote, shreg[DATABITS-1:1]};
          if (at_wrap) begin
            if (bit_idx == LAST_BIT) state <= par_en ? PARITY : STOP1;
            else                     bit_idx <= bit_idx + 4'd1;
          end
        end
        PARITY: begin
          cnt <= cnt_inc;
          if (at_dec) begin
            perr_reg <= (par_lat == 2'd1) ? ~(^shreg ^ vote) : (^shreg ^ vote);
`ifdef UART_RECV_BREAK_DET_EN
            pbit_reg <= vote;
`endif
          end
          if (at_wrap) state <= STOP1;
        end
        STOP1: begin
          cnt <= cnt_inc;
          // A low stop bit usually means a break or line fault, so wait for the line to recover.
          if (commit)       state <= frame_ferr ? WAIT_IDLE : IDLE;
          else if (at_wrap) state <= STOP2;
        end
        STOP2: begin
          cnt <= cnt_inc;
          if (commit) state <= frame_ferr ? WAIT_IDLE : IDLE;
        end
        default: state <= WAIT_IDLE;
      endcase
    end
  end

  always_comb begin
    full       = (count == FULL_CNT);
    do_pop     = out_valid && out_ready && !soft_reset;
    do_push    = push && (!full || do_pop);
    ovr_set    = push && full && !do_pop;
    count_next = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    rd_next    = rd_ptr + AW'(do_pop);
    din        = {frame_ferr, perr_reg, shreg};
    // When no older entry remains behind the head, the incoming word becomes the head directly.
    head_next  = ((count - (AW+1)'(do_pop)) == '0) ? din : mem[rd_next];
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_perr  <= 1'b0;
      out_ferr  <= 1'b0;
      overrun   <= 1'b0;
      cts       <= 1'b0;
    end else if (soft_reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      cts       <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr    <= rd_next;
      count     <= count_next;
      out_valid <= (count_next != '0);
      if (count_next != '0) {out_ferr, out_perr, out_data} <= head_next;
      overrun   <= ovr_set | (overrun & ~ovr_clr);
      cts       <= (count < CTS_LIMIT);
    end
  end

  assign fill = count;

endmodule
